// File: rtl/sdp_ram_stream_reader_if.sv
// Bundles the burst command, the RAM read port and the output stream of the
// BRAM stream reader. The master side is the reader itself; the slave side is
// the surrounding system (command source, RAM, downstream consumer).
interface sdp_ram_stream_reader_if #(
   parameter int MEM_ADDR_WIDTH = 9,
   parameter int MEM_WORD_WIDTH = 64,
   parameter int LEN_WIDTH      = MEM_ADDR_WIDTH + 1
);
   logic                      cmd_valid;
   logic                      cmd_ready;
   logic [MEM_ADDR_WIDTH-1:0] cmd_base_addr;
   logic [LEN_WIDTH-1:0]      cmd_len;
   logic [MEM_ADDR_WIDTH-1:0] rd_addr;
   logic [MEM_WORD_WIDTH-1:0] rd_data_in;
   logic [MEM_WORD_WIDTH-1:0] m_data;
   logic                      m_valid;
   logic                      m_ready;
   logic                      m_last;
   logic                      busy;
   logic                      done;

   modport master (
      input  cmd_valid, cmd_base_addr, cmd_len, rd_data_in, m_ready,
      output cmd_ready, rd_addr, m_data, m_valid, m_last, busy, done
   );

   modport slave (
      output cmd_valid, cmd_base_addr, cmd_len, rd_data_in, m_ready,
      input  cmd_ready, rd_addr, m_data, m_valid, m_last, busy, done
   );
endinterface

// File: rtl/sdp_ram_stream_reader.sv
// Read-side client for the 64x512 simple dual-port BRAM. Takes a burst
// command, walks the RAM read address, absorbs the one-cycle read latency and
// presents the words as a valid/ready stream through a 2-entry FIFO.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | cmd_ready high; waits for a command (len=0 completes in place)
//   RUN   | issuing reads and draining beats until the m_last beat pops
module sdp_ram_stream_reader #(
   parameter int MEM_ADDR_WIDTH = 9,
   parameter int MEM_WORD_WIDTH = 64,
   parameter int LEN_WIDTH      = MEM_ADDR_WIDTH + 1
) (
   input  logic                    clk,
   input  logic                    rst,
   sdp_ram_stream_reader_if.master rdr
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t                    state_q, state_d;
   logic [MEM_ADDR_WIDTH-1:0] rd_addr_q;
   logic [LEN_WIDTH-1:0]      len_q;
   logic [LEN_WIDTH-1:0]      issued_q;
   logic [LEN_WIDTH-1:0]      beats_left_q;
   logic                      inflight_q;
   logic                      done_q;
   logic [MEM_WORD_WIDTH-1:0] fifo_q [2];
   logic                      wr_ptr_q;
   logic                      rd_ptr_q;
   logic [1:0]                occ_q;

   logic       cmd_ready_w;
   logic       busy_w;
   logic       cmd_fire;
   logic       len_zero;
   logic       pop;
   logic       push;
   logic       rd_fire;
   logic       last_w;
   logic [2:0] slots_used;
   logic [2:0] slots_avail;

   assign cmd_fire    = rdr.cmd_valid & cmd_ready_w;
   assign len_zero    = (rdr.cmd_len == '0);
   assign pop         = (occ_q != 2'd0) & rdr.m_ready;
   assign push        = inflight_q;
   assign last_w      = (occ_q != 2'd0) & (beats_left_q == LEN_WIDTH'(1));

   // A read may issue only if the word it returns is guaranteed a FIFO slot,
   // counting the word already in flight and the pop happening this edge.
   assign slots_used  = {1'b0, occ_q} + {2'b00, inflight_q};
   assign slots_avail = 3'd2 + {2'b00, pop};
   assign rd_fire     = (state_q == ST_RUN) & (issued_q < len_q) &
                        (slots_used < slots_avail);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: a zero-length command completes without leaving IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (cmd_fire && !len_zero) state_d = ST_RUN;
         ST_RUN:  if (pop && last_w)         state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State-decoded outputs.
   always_comb begin
      cmd_ready_w = 1'b0;
      busy_w      = 1'b0;
      case (state_q)
         ST_IDLE: cmd_ready_w = 1'b1;
         ST_RUN:  busy_w      = 1'b1;
         default: cmd_ready_w = 1'b0;
      endcase
   end

   // Burst counters, read address walk and completion pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_addr_q    <= '0;
         len_q        <= '0;
         issued_q     <= '0;
         beats_left_q <= '0;
         inflight_q   <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         if (cmd_fire && !len_zero) begin
            rd_addr_q    <= rdr.cmd_base_addr;
            len_q        <= rdr.cmd_len;
            issued_q     <= '0;
            beats_left_q <= rdr.cmd_len;
         end else begin
            if (rd_fire) begin
               rd_addr_q <= rd_addr_q + MEM_ADDR_WIDTH'(1);
               issued_q  <= issued_q + LEN_WIDTH'(1);
            end
            if (pop) begin
               beats_left_q <= beats_left_q - LEN_WIDTH'(1);
            end
         end
         inflight_q <= rd_fire;
         done_q     <= (cmd_fire & len_zero) | (pop & last_w);
      end
   end

   // Two-entry output FIFO; words land here one cycle after their read issues.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         occ_q    <= 2'd0;
      end else begin
         if (push) begin
            fifo_q[wr_ptr_q] <= rdr.rd_data_in;
            wr_ptr_q         <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         case ({push, pop})
            2'b10:   occ_q <= occ_q + 2'd1;
            2'b01:   occ_q <= occ_q - 2'd1;
            default: occ_q <= occ_q;
         endcase
      end
   end

   assign rdr.cmd_ready = cmd_ready_w;
   assign rdr.busy      = busy_w;
   assign rdr.rd_addr   = rd_addr_q;
   assign rdr.m_data    = fifo_q[rd_ptr_q];
   assign rdr.m_valid   = (occ_q != 2'd0);
   assign rdr.m_last    = last_w;
   assign rdr.done      = done_q;

endmodule

// File: tb/tb_sdp_ram_stream_reader.sv
// Directed bench for the BRAM stream reader: a per-cycle vector table for the
// basic and zero-length bursts, then hand-written multi-cycle sequences.
module tb_sdp_ram_stream_reader;
   localparam int AW = 9;
   localparam int WW = 64;
   localparam int LW = AW + 1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sdp_ram_stream_reader_if #(.MEM_ADDR_WIDTH(AW), .MEM_WORD_WIDTH(WW), .LEN_WIDTH(LW)) bus ();

   sdp_ram_stream_reader #(.MEM_ADDR_WIDTH(AW), .MEM_WORD_WIDTH(WW), .LEN_WIDTH(LW)) dut (
      .clk (clk),
      .rst (rst),
      .rdr (bus)
   );

   // RAM model: one-cycle registered read, word[a] = a.
   logic [WW-1:0] ram [512];
   always @(posedge clk) bus.rd_data_in <= ram[bus.rd_addr];

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   typedef struct {
      logic          cv;
      logic [AW-1:0] base;
      logic [LW-1:0] len;
      logic          mr;
      logic          rdy;
      logic          bsy;
      logic          mv;
      logic          last;
      logic          dn;
      logic [WW-1:0] data;
      logic          chk_addr;
      logic [AW-1:0] addr;
   } vec_t;

   vec_t vecs [17];

   function automatic vec_t mk(input logic cv, input logic [AW-1:0] base, input logic [LW-1:0] len,
                               input logic rdy, input logic bsy, input logic mv, input logic last,
                               input logic dn, input logic [WW-1:0] data,
                               input logic chk_addr, input logic [AW-1:0] addr);
      vec_t v;
      v.cv = cv; v.base = base; v.len = len; v.mr = 1'b1;
      v.rdy = rdy; v.bsy = bsy; v.mv = mv; v.last = last; v.dn = dn;
      v.data = data; v.chk_addr = chk_addr; v.addr = addr;
      return v;
   endfunction

   // Issue one burst and drain it, checking data order, m_last, stall stability
   // and the done pulse. bp selects a fixed m_ready stall pattern.
   task automatic run_burst(input string nm, input logic [AW-1:0] base, input logic [LW-1:0] len,
                            input bit bp);
      logic [7:0]    bp_pat = 8'b0110_1001;
      int            k = 0;
      int            cyc = 0;
      bit            got_done = 0;
      bit            stalled = 0;
      logic [WW-1:0] held;
      logic [AW-1:0] a;
      bus.cmd_valid     = 1'b1;
      bus.cmd_base_addr = base;
      bus.cmd_len       = len;
      bus.m_ready       = 1'b1;
      check({nm, "_cmd_ready"}, 64'(bus.cmd_ready), 64'd1);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      while (!got_done && cyc < 100) begin
         bus.m_ready = bp ? bp_pat[cyc % 8] : 1'b1;
         if (stalled) begin
            check({nm, "_stall_valid"}, 64'(bus.m_valid), 64'd1);
            check({nm, "_stall_data"}, bus.m_data, held);
         end
         if (bus.m_valid) begin
            if (bus.m_ready) begin
               a = base + AW'(k);
               check($sformatf("%s_data%0d", nm, k), bus.m_data, 64'(a));
               check($sformatf("%s_last%0d", nm, k), 64'(bus.m_last), 64'(k == int'(len) - 1));
               k++;
               stalled = 0;
            end else begin
               stalled = 1;
               held = bus.m_data;
            end
         end
         if (bus.done) got_done = 1;
         @(negedge clk);
         cyc++;
      end
      check({nm, "_beats"}, 64'(k), 64'(len));
      check({nm, "_done_seen"}, 64'(got_done), 64'd1);
      check({nm, "_done_pulse"}, 64'(bus.done), 64'd0);
   endtask

   initial begin
      for (int a = 0; a < 512; a++) ram[a] = 64'(a);
      bus.cmd_valid = 1'b0; bus.cmd_base_addr = '0; bus.cmd_len = '0; bus.m_ready = 1'b1;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
      check("rst_rd_addr",   64'(bus.rd_addr),   64'd0);
      check("rst_m_data",    bus.m_data,         64'd0);
      check("rst_m_valid",   64'(bus.m_valid),   64'd0);
      check("rst_m_last",    64'(bus.m_last),    64'd0);
      check("rst_busy",      64'(bus.busy),      64'd0);
      check("rst_done",      64'(bus.done),      64'd0);
      rst = 1'b0;

      //           cv    base    len   rdy  bsy  mv   last dn   data  chk  addr
      vecs[0]  = mk(1'b1, 9'h010, 10'd4, 1'b1,1'b0,1'b0,1'b0,1'b0, 64'h0, 1'b0, 9'h0);
      vecs[1]  = mk(1'b0, 9'h000, 10'd0, 1'b0,1'b1,1'b0,1'b0,1'b0, 64'h0, 1'b1, 9'h010);
      vecs[2]  = mk(1'b0, 9'h000, 10'd0, 1'b0,1'b1,1'b0,1'b0,1'b0, 64'h0, 1'b0, 9'h0);
      vecs[3]  = mk(1'b0, 9'h000, 10'd0, 1'b0,1'b1,1'b1,1'b0,1'b0, 64'h10,1'b0, 9'h0);
      vecs[4]  = mk(1'b0, 9'h000, 10'd0, 1'b0,1'b1,1'b1,1'b0,1'b0, 64'h11,1'b0, 9'h0);
      vecs[5]  = mk(1'b0, 9'h000, 10'd0, 1'b0,1'b1,1'b1,1'b0,1'b0, 64'h12,1'b0, 9'h0);
      vecs[6]  = mk(1'b0, 9'h000, 10'd0, 1'b0,1'b1,1'b1,1'b1,1'b0, 64'h13,1'b0, 9'h0);
      vecs[7]  = mk(1'b0, 9'h000, 10'd0, 1'b1,1'b0,1'b0,1'b0,1'b1, 64'h0, 1'b0, 9'h0);
      vecs[8]  = mk(1'b0, 9'h000, 10'd0, 1'b1,1'b0,1'b0,1'b0,1'b0, 64'h0, 1'b1, 9'h014);
      vecs[9]  = mk(1'b1, 9'h1AB, 10'd0, 1'b1,1'b0,1'b0,1'b0,1'b0, 64'h0, 1'b0, 9'h0);
      vecs[10] = mk(1'b1, 9'h005, 10'd2, 1'b1,1'b0,1'b0,1'b0,1'b1, 64'h0, 1'b1, 9'h014);
      vecs[11] = mk(1'b0, 9'h000, 10'd0, 1'b0,1'b1,1'b0,1'b0,1'b0, 64'h0, 1'b1, 9'h005);
      vecs[12] = mk(1'b0, 9'h000, 10'd0, 1'b0,1'b1,1'b0,1'b0,1'b0, 64'h0, 1'b0, 9'h0);
      vecs[13] = mk(1'b0, 9'h000, 10'd0, 1'b0,1'b1,1'b1,1'b0,1'b0, 64'h5, 1'b0, 9'h0);
      vecs[14] = mk(1'b0, 9'h000, 10'd0, 1'b0,1'b1,1'b1,1'b1,1'b0, 64'h6, 1'b0, 9'h0);
      vecs[15] = mk(1'b0, 9'h000, 10'd0, 1'b1,1'b0,1'b0,1'b0,1'b1, 64'h0, 1'b1, 9'h007);
      vecs[16] = mk(1'b0, 9'h000, 10'd0, 1'b1,1'b0,1'b0,1'b0,1'b0, 64'h0, 1'b0, 9'h0);

      for (int i = 0; i < 17; i++) begin
         bus.cmd_valid     = vecs[i].cv;
         bus.cmd_base_addr = vecs[i].base;
         bus.cmd_len       = vecs[i].len;
         bus.m_ready       = vecs[i].mr;
         check($sformatf("vec%0d_cmd_ready", i), 64'(bus.cmd_ready), 64'(vecs[i].rdy));
         check($sformatf("vec%0d_busy", i),      64'(bus.busy),      64'(vecs[i].bsy));
         check($sformatf("vec%0d_m_valid", i),   64'(bus.m_valid),   64'(vecs[i].mv));
         check($sformatf("vec%0d_m_last", i),    64'(bus.m_last),    64'(vecs[i].last));
         check($sformatf("vec%0d_done", i),      64'(bus.done),      64'(vecs[i].dn));
         if (vecs[i].mv)
            check($sformatf("vec%0d_m_data", i), bus.m_data, vecs[i].data);
         if (vecs[i].chk_addr)
            check($sformatf("vec%0d_rd_addr", i), 64'(bus.rd_addr), 64'(vecs[i].addr));
         @(negedge clk);
      end

      // Address wrap across the top of the RAM.
      run_burst("wrap", 9'h1FE, 10'd4, 1'b0);
      check("wrap_rd_addr_end", 64'(bus.rd_addr), 64'h002);

      // Back-pressure with a fixed stall pattern.
      run_burst("bp", 9'h040, 10'd8, 1'b1);

      // Back-to-back: second command offered in the done cycle of the first.
      begin
         logic [WW-1:0] exp_q [6] = '{64'h20, 64'h21, 64'h22, 64'h30, 64'h31, 64'h32};
         int  beats = 0, lasts = 0, dones = 0, cyc = 0;
         bool_seq: begin end
         bus.cmd_valid = 1'b1; bus.cmd_base_addr = 9'h020; bus.cmd_len = 10'd3; bus.m_ready = 1'b1;
         @(negedge clk);
         bus.cmd_valid = 1'b0;
         while (dones < 2 && cyc < 60) begin
            bus.cmd_valid = 1'b0;
            if (bus.m_valid) begin
               if (beats < 6) check($sformatf("b2b_data%0d", beats), bus.m_data, exp_q[beats]);
               check($sformatf("b2b_last%0d", beats), 64'(bus.m_last),
                     64'(beats == 2 || beats == 5));
               if (bus.m_last) lasts++;
               beats++;
            end
            if (bus.done) begin
               dones++;
               if (dones == 1) begin
                  check("b2b_ready_on_done", 64'(bus.cmd_ready), 64'd1);
                  bus.cmd_valid = 1'b1; bus.cmd_base_addr = 9'h030; bus.cmd_len = 10'd3;
               end
            end
            @(negedge clk);
            cyc++;
         end
         bus.cmd_valid = 1'b0;
         check("b2b_beats", 64'(beats), 64'd6);
         check("b2b_lasts", 64'(lasts), 64'd2);
         check("b2b_dones", 64'(dones), 64'd2);
      end

      // Reset in the middle of a 6-beat burst, then a clean 2-beat burst.
      begin
         int beats = 0, cyc = 0;
         bus.cmd_valid = 1'b1; bus.cmd_base_addr = 9'h050; bus.cmd_len = 10'd6; bus.m_ready = 1'b1;
         @(negedge clk);
         bus.cmd_valid = 1'b0;
         while (beats < 2 && cyc < 20) begin
            if (bus.m_valid) beats++;
            @(negedge clk);
            cyc++;
         end
         check("mid_rst_two_beats", 64'(beats), 64'd2);
         rst = 1'b1;
         @(negedge clk);
         check("mid_rst_m_valid",   64'(bus.m_valid),   64'd0);
         check("mid_rst_busy",      64'(bus.busy),      64'd0);
         check("mid_rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
         rst = 1'b0;
         run_burst("post_rst", 9'h060, 10'd2, 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
